// File: rtl/nn_input_packer_if.sv
// Byte-stream and packed-beat bus between the producer, nn_input_packer and
// the network controller. The slave modport is the packer's view.
interface nn_input_packer_if #(
   parameter int LANES = 50
) ();
   logic                 s_valid;
   logic [7:0]           s_data;
   logic                 s_last;
   logic                 s_ready;
   logic [8*LANES-1:0]   out_data;
   logic [7:0]           count;
   logic                 out_beat;

   modport master (
      output s_valid, s_data, s_last,
      input  s_ready, out_data, count, out_beat
   );

   modport slave (
      input  s_valid, s_data, s_last,
      output s_ready, out_data, count, out_beat
   );
endinterface

// File: rtl/nn_input_packer.sv
// nn_input_packer: packs a byte stream into LANES-byte beats and presents
// each beat with its index on count for the NN controller. A frame is
// IN_BEATS (input) or WT_BEATS (weight) beats, chosen per frame.
// Optional feature macro NNPACK_LAST_CHECK_EN adds the sticky frame_err
// output, which flags s_last misplacement against the nominal frame length.
module nn_input_packer #(
   parameter int LANES    = 50,
   parameter int IN_BEATS = 20,
   parameter int WT_BEATS = 21
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               frame_req,
   input  logic               frame_sel,
   nn_input_packer_if.slave   bus,
   output logic               frame_done,
   output logic               busy
`ifdef NNPACK_LAST_CHECK_EN
   ,
   output logic               frame_err
`endif
);

   typedef enum logic [1:0] {IDLE, FILL, LAST} state_t;

   localparam int              LW       = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [LW-1:0]   LANE_MAX = LW'(LANES - 1);
   localparam logic [7:0]      IN_B     = 8'(IN_BEATS);
   localparam logic [7:0]      WT_B     = 8'(WT_BEATS);

   state_t                     state_q, state_d;
   logic [LW-1:0]              lane_idx_q, lane_idx_d;
   logic [7:0]                 beat_idx_q, beat_idx_d;
   logic [7:0]                 beats_total_q, beats_total_d;
   logic [LANES-1:0][7:0]      fill_q, fill_d;
   logic [LANES-1:0][7:0]      out_data_q, out_data_d;
   logic [7:0]                 count_q, count_d;
   logic                       out_beat_q, out_beat_d;
   logic                       frame_done_q, frame_done_d;
   logic                       accept;
   logic                       beat_end;
   logic                       final_beat;
`ifdef NNPACK_LAST_CHECK_EN
   logic                       frame_err_q, frame_err_d;
`endif

   assign accept     = bus.s_valid && (state_q == FILL);
   assign beat_end   = accept && (lane_idx_q == LANE_MAX);
   assign final_beat = (beat_idx_q == beats_total_q - 8'd1);

   // Next-state and datapath: fill lanes, emit a beat every LANES bytes,
   // hold the last beat one cycle in LAST, then park outputs at zero.
   always_comb begin
      state_d       = state_q;
      lane_idx_d    = lane_idx_q;
      beat_idx_d    = beat_idx_q;
      beats_total_d = beats_total_q;
      fill_d        = fill_q;
      out_data_d    = out_data_q;
      count_d       = count_q;
      out_beat_d    = 1'b0;
      frame_done_d  = 1'b0;
`ifdef NNPACK_LAST_CHECK_EN
      frame_err_d   = frame_err_q;
`endif
      case (state_q)
         IDLE: begin
            if (frame_req) begin
               state_d       = FILL;
               beats_total_d = frame_sel ? WT_B : IN_B;
               lane_idx_d    = '0;
               beat_idx_d    = 8'd0;
`ifdef NNPACK_LAST_CHECK_EN
               frame_err_d   = 1'b0;
`endif
            end
         end
         FILL: begin
            if (accept) begin
               fill_d[lane_idx_q] = bus.s_data;
               lane_idx_d         = lane_idx_q + LW'(1);
`ifdef NNPACK_LAST_CHECK_EN
               if (bus.s_last != (beat_end && final_beat)) begin
                  frame_err_d = 1'b1;
               end
`endif
               if (beat_end) begin
                  out_data_d = fill_d;
                  count_d    = beat_idx_q;
                  out_beat_d = 1'b1;
                  lane_idx_d = '0;
                  beat_idx_d = beat_idx_q + 8'd1;
                  if (final_beat) begin
                     state_d = LAST;
                  end
               end
            end
         end
         LAST: begin
            // Park at zero so the controller never sees a stale terminal index.
            state_d      = IDLE;
            frame_done_d = 1'b1;
            count_d      = 8'd0;
            out_data_d   = '0;
         end
         default: state_d = IDLE;
      endcase
   end

   // Control and presented-beat registers; async reset returns all outputs to zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         lane_idx_q    <= '0;
         beat_idx_q    <= 8'd0;
         beats_total_q <= 8'd0;
         out_data_q    <= '0;
         count_q       <= 8'd0;
         out_beat_q    <= 1'b0;
         frame_done_q  <= 1'b0;
`ifdef NNPACK_LAST_CHECK_EN
         frame_err_q   <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         lane_idx_q    <= lane_idx_d;
         beat_idx_q    <= beat_idx_d;
         beats_total_q <= beats_total_d;
         out_data_q    <= out_data_d;
         count_q       <= count_d;
         out_beat_q    <= out_beat_d;
         frame_done_q  <= frame_done_d;
`ifdef NNPACK_LAST_CHECK_EN
         frame_err_q   <= frame_err_d;
`endif
      end
   end

   // Fill register holds only partial-beat data; lane_idx reset discards it.
   always_ff @(posedge clk) begin
      fill_q <= fill_d;
   end

   assign bus.s_ready  = (state_q == FILL);
   assign bus.out_data = out_data_q;
   assign bus.count    = count_q;
   assign bus.out_beat = out_beat_q;
   assign frame_done   = frame_done_q;
   assign busy         = (state_q != IDLE);
`ifdef NNPACK_LAST_CHECK_EN
   assign frame_err    = frame_err_q;
`endif

endmodule

// File: doc/nn_input_packer.md
# nn_input_packer

Upstream feeder for the neural-network controller. It accepts a byte stream of feature samples or weights over a valid/ready handshake and packs every `LANES` bytes into one wide beat. Each beat is presented on the parallel lane bus together with its beat index on `count`, which the controller consumes as `in1..inN` and `count`. One frame is a fixed number of beats: either an input frame or a weight frame, selected per frame.

## Interface
Parameters:
- `LANES`, default 50: bytes per beat; lane 0 maps to `in1`.
- `IN_BEATS`, default 20: beats per input frame (1000 samples).
- `WT_BEATS`, default 21: beats per weight frame (neuron weights + bias).

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `frame_req`, in, 1: one-cycle pulse that starts a frame. Ignored unless in IDLE.
- `frame_sel`, in, 1: frame type, sampled with `frame_req`. 0 = input frame (`IN_BEATS`), 1 = weight frame (`WT_BEATS`).
- `s_valid`, in, 1: byte valid.
- `s_data`, in, 8: byte.
- `s_last`, in, 1: producer marks the final byte of the frame.
- `s_ready`, out, 1: byte accepted when `s_valid && s_ready`.
- `out_data`, out, 8*LANES: presented beat; lane k = bits [8k+7:8k].
- `count`, out, 8: index of the beat currently presented.
- `out_beat`, out, 1: one-cycle strobe when a new beat appears.
- `frame_done`, out, 1: one-cycle pulse at frame end.
- `busy`, out, 1: high whenever the FSM is not in IDLE.
- `frame_err`, out, 1: sticky error flag (present only with the `_EN` macro).

## Operation
- FSM states: IDLE, FILL, LAST.
- IDLE → FILL on `frame_req`:
  - latch `beats_total` from `frame_sel`;
  - clear the lane index (0..LANES-1) and the beat index.
- FILL, `s_ready` = 1:
  - each accepted byte is written into fill-register lane[lane_idx], and lane_idx increments.
  - On the LANES-th byte: copy the fill register, including that byte, into `out_data`; set `count` to the beat index; pulse `out_beat`; reset lane_idx to 0; increment the beat index.
  - When the completed beat is beat `beats_total-1`, go to LAST.
- LAST, `s_ready` = 0:
  - the final beat is held for exactly one cycle;
  - next cycle: `frame_done` = 1, `count` = 0, `out_data` = 0, go to IDLE.
- IDLE parks at `count` = 0 and `out_data` = 0. This guarantees the controller never sees a stale terminal index (19 or 20) when it enters its next load phase.
- Between beats, `count` and `out_data` hold the last presented beat unchanged. The controller may rewrite the same address any number of times.
- `s_valid` gaps are legal anywhere and only stall filling.
- `frame_req` while `busy` is ignored; there is no queueing.
- Widths: beat index is 8 bits. `IN_BEATS` and `WT_BEATS` must each be ≤ 255.

## Timing
- Reset values: `s_ready` = 0, `out_data` = 0, `count` = 0, `out_beat` = 0, `frame_done` = 0, `busy` = 0, `frame_err` = 0. State = IDLE.
- `frame_req` at cycle t → `s_ready` = 1 from t+1.
- Byte completing a beat accepted at edge t → `out_data`, `count`, and `out_beat` update at t+1 (1-cycle latency).
- Maximum rate: one byte per clock, so one beat per LANES clocks.
- Final beat visible for one cycle (state LAST); `frame_done` and park to 0 follow in the next cycle.
- Reset mid-frame: partial beat is discarded; all outputs return to reset values asynchronously.
- A beat completing in the same cycle as a new `s_valid` byte cannot occur in LAST, because `s_ready` = 0 there.

## Configuration
- Macro `NNPACK_LAST_CHECK_EN`.
- Defined:
  - `frame_err` is set if `s_last` accompanies any byte other than the frame's final byte.
  - `frame_err` is also set if the final byte arrives without `s_last`.
  - The frame still completes at its nominal length.
  - `frame_err` clears only on `rst` or on the next accepted `frame_req`.
- Undefined:
  - `s_last` is ignored;
  - the `frame_err` port is absent;
  - no check logic is built.

## Test plan
- Input frame: `frame_sel` = 0; stream 1000 bytes of value (i mod 256) back-to-back → 20 `out_beat` strobes with `count` 0..19, beat 7 lane 0 = 8'd94, `frame_done` 1 cycle after `count` = 19, then `count` = 0.
- Weight frame with gaps: `frame_sel` = 1; random `s_valid` duty 30% over 1050 bytes → `count` 0..20 strictly increasing, each beat's data held until the next beat, `s_ready` = 0 during LAST.
- Ignored request: `frame_req` pulsed mid-frame → no effect; beat sequence identical to the undisturbed run.
- Reset mid-frame: assert `rst` after 73 bytes → all outputs 0 immediately; a new frame then yields beat 0 built only from post-reset bytes.
- Back-to-back frames: `frame_req` in the cycle after `frame_done` → second frame starts cleanly at `count` = 0, no missing or duplicated beats.
- `NNPACK_LAST_CHECK_EN`: `s_last` on byte 500 of an input frame → `frame_err` = 1 and `frame_done` still after byte 1000; correct `s_last` on the next frame → `frame_err` cleared at its `frame_req` and stays 0.
